// File: rtl/motoro3_step_sequencer.sv
// Six-step commutation timebase: period counter, step code and step tally.
// Optional M3_STEP_LIMIT_EN adds m3r_stepLimit to auto-stop after N steps.
module motoro3_step_sequencer #(
   parameter int         STEP_NUM   = 6,
   parameter logic [3:0] STEP_OFF   = 4'hF,
   parameter int         MIN_PERIOD = 2
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        m3r_enable,
   input  logic        m3r_dir,
   input  logic [24:0] m3r_stepCNT_speedSET,
   output logic [24:0] m3cnt,
   output logic        m3cntLast1,
   output logic [3:0]  m3step,
   output logic        m3stepAdv,
   output logic        m3running,
   output logic [15:0] m3stepTotal
`ifdef M3_STEP_LIMIT_EN
   ,
   input  logic [15:0] m3r_stepLimit
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOPPING
   } state_t;

   localparam logic [24:0] MIN_P = 25'(MIN_PERIOD);
   localparam logic [3:0]  LAST_STEP = 4'(STEP_NUM - 1);

   state_t      state;
   logic [24:0] period;
   logic        dir_sh;

   logic [24:0] speed_clamp;
   logic [24:0] cnt_inc;
   logic        last_inc;
   logic [3:0]  step_fwd;
   logic [3:0]  step_rev;
   logic [15:0] total_inc;
   logic        run_req;
   logic        limit_hit;

`ifdef M3_STEP_LIMIT_EN
   logic limited;

   // Once the limit trips, enable must be seen low before a restart.
   assign run_req   = m3r_enable & ~limited;
   assign limit_hit = (m3r_stepLimit != 16'd0) &&
                      (total_inc == m3r_stepLimit);
`else
   assign run_req   = m3r_enable;
   assign limit_hit = 1'b0;
`endif

   always_comb begin
      speed_clamp = m3r_stepCNT_speedSET;
      if (m3r_stepCNT_speedSET < MIN_P)
         speed_clamp = MIN_P;
   end

   assign cnt_inc   = m3cnt + 25'd1;
   assign last_inc  = (cnt_inc == period - 25'd1);
   assign total_inc = m3stepTotal + 16'd1;
   assign step_fwd  = (m3step == LAST_STEP) ? 4'd0 : m3step + 4'd1;
   assign step_rev  = (m3step == 4'd0) ? LAST_STEP : m3step - 4'd1;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state       <= IDLE;
         m3cnt       <= '0;
         m3cntLast1  <= 1'b0;
         m3step      <= STEP_OFF;
         m3stepAdv   <= 1'b0;
         m3running   <= 1'b0;
         m3stepTotal <= '0;
         period      <= MIN_P;
         dir_sh      <= 1'b1;
`ifdef M3_STEP_LIMIT_EN
         limited     <= 1'b0;
`endif
      end else begin
         m3stepAdv <= 1'b0;
`ifdef M3_STEP_LIMIT_EN
         if (!m3r_enable)
            limited <= 1'b0;
`endif
         case (state)
            IDLE: begin
               m3cnt      <= '0;
               m3cntLast1 <= 1'b0;
               if (run_req) begin
                  state       <= RUN;
                  m3step      <= 4'd0;
                  m3stepAdv   <= 1'b1;
                  m3stepTotal <= '0;
                  m3running   <= 1'b1;
                  period      <= speed_clamp;
                  dir_sh      <= m3r_dir;
               end
            end
            RUN, STOPPING: begin
               if (m3cntLast1) begin
                  m3cnt      <= '0;
                  m3cntLast1 <= 1'b0;
                  if (state == RUN || run_req) begin
                     m3stepAdv   <= 1'b1;
                     m3stepTotal <= total_inc;
                     m3step      <= dir_sh ? step_fwd : step_rev;
                     period      <= speed_clamp;
                     dir_sh      <= m3r_dir;
                     if (run_req && !limit_hit) begin
                        state <= RUN;
                     end else begin
                        state <= STOPPING;
`ifdef M3_STEP_LIMIT_EN
                        if (limit_hit)
                           limited <= 1'b1;
`endif
                     end
                  end else begin
                     state     <= IDLE;
                     m3step    <= STEP_OFF;
                     m3running <= 1'b0;
                  end
               end else begin
                  m3cnt      <= cnt_inc;
                  m3cntLast1 <= last_inc;
                  state      <= run_req ? RUN : STOPPING;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
